// File: rtl/handshake_const_sink_if.sv
// Valid/ready bundle for the constant sink: data token in, dataless control token out.
// The slave modport is the sink itself; the master modport drives it.
interface handshake_const_sink_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins,
    output ins_valid,
    input  ins_ready,
    input  outs_valid,
    output outs_ready
  );

  modport slave (
    input  ins,
    input  ins_valid,
    output ins_ready,
    output outs_valid,
    input  outs_ready
  );
endinterface

// File: rtl/handshake_const_sink.sv
// Terminator that checks each accepted token against a constant and re-emits a dataless token via a 2-deep elastic buffer.
// Optional CONST_SINK_DROP_MISMATCH_EN: mismatching tokens are consumed without emitting a control token.
module handshake_const_sink #(
  parameter int unsigned          DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] EXPECTED  = DATA_WIDTH'(24'hFD652C),
  parameter int unsigned          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  handshake_const_sink_if.slave bus,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic                  mismatch_sticky,
  output logic [DATA_WIDTH-1:0] first_bad
);

  localparam int unsigned          OCC_WIDTH = 2;
  localparam logic [OCC_WIDTH-1:0] OCC_EMPTY = OCC_WIDTH'(0);
  localparam logic [OCC_WIDTH-1:0] OCC_ONE   = OCC_WIDTH'(1);
  localparam logic [OCC_WIDTH-1:0] OCC_FULL  = OCC_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic                  ins_ready_q, outs_valid_q;
  logic [CNT_WIDTH-1:0]  match_q, match_d;
  logic [CNT_WIDTH-1:0]  mismatch_q, mismatch_d;
  logic                  sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] first_bad_q, first_bad_d;

  logic accept, pop, hit, push;

  // Handshake decode and next-state for buffer occupancy and statistics
  always_comb begin
    accept      = bus.ins_valid & ins_ready_q;
    pop         = outs_valid_q & bus.outs_ready;
    hit         = (bus.ins == EXPECTED);
`ifdef CONST_SINK_DROP_MISMATCH_EN
    push        = accept & hit;
`else
    push        = accept;
`endif
    occ_d       = occ_q;
    match_d     = match_q;
    mismatch_d  = mismatch_q;
    sticky_d    = sticky_q;
    first_bad_d = first_bad_q;

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    // Saturating counters; first miss latches its value once
    if (accept) begin
      if (hit) begin
        if (match_q != CNT_MAX) match_d = match_q + CNT_ONE;
      end else begin
        if (mismatch_q != CNT_MAX) mismatch_d = mismatch_q + CNT_ONE;
        if (!sticky_q) begin
          sticky_d    = 1'b1;
          first_bad_d = bus.ins;
        end
      end
    end
  end

  // Handshake flags are flopped from the next occupancy so neither depends combinationally on outs_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q        <= OCC_EMPTY;
      ins_ready_q  <= 1'b1;
      outs_valid_q <= 1'b0;
      match_q      <= '0;
      mismatch_q   <= '0;
      sticky_q     <= 1'b0;
      first_bad_q  <= '0;
    end else begin
      occ_q        <= occ_d;
      ins_ready_q  <= (occ_d != OCC_FULL);
      outs_valid_q <= (occ_d != OCC_EMPTY);
      match_q      <= match_d;
      mismatch_q   <= mismatch_d;
      sticky_q     <= sticky_d;
      first_bad_q  <= first_bad_d;
    end
  end

  assign bus.ins_ready   = ins_ready_q;
  assign bus.outs_valid  = outs_valid_q;
  assign match_cnt       = match_q;
  assign mismatch_cnt    = mismatch_q;
  assign mismatch_sticky = sticky_q;
  assign first_bad       = first_bad_q;

endmodule

// File: tb/tb_handshake_const_sink.sv
// Randomized bench for handshake_const_sink against a token-count reference model.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_handshake_const_sink;

  localparam int unsigned DW   = 24;
  localparam logic [23:0] EXP  = 24'hFD652C;
  localparam int          MAX16 = 65535;
  localparam int          MAX4  = 15;
`ifdef CONST_SINK_DROP_MISMATCH_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk;
  logic rst;

  handshake_const_sink_if #(.DATA_WIDTH(DW)) bus ();
  handshake_const_sink_if #(.DATA_WIDTH(DW)) bus_sat ();

  logic [15:0]   match_cnt, mismatch_cnt;
  logic          mismatch_sticky;
  logic [DW-1:0] first_bad;
  logic [3:0]    match_cnt4, mismatch_cnt4;
  logic          mismatch_sticky4;
  logic [DW-1:0] first_bad4;

  assign bus_sat.ins        = bus.ins;
  assign bus_sat.ins_valid  = bus.ins_valid;
  assign bus_sat.outs_ready = bus.outs_ready;

  handshake_const_sink #(.DATA_WIDTH(DW), .EXPECTED(EXP), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .mismatch_sticky(mismatch_sticky), .first_bad(first_bad)
  );

  handshake_const_sink #(.DATA_WIDTH(DW), .EXPECTED(EXP), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_sat),
    .match_cnt(match_cnt4), .mismatch_cnt(mismatch_cnt4),
    .mismatch_sticky(mismatch_sticky4), .first_bad(first_bad4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: plain token counts and unbounded statistics
  int          m_occ;
  int          m_match;
  int          m_mis;
  bit          m_sticky;
  logic [23:0] m_first;
  bit          last_acc;
  int          n_pops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all();
    check("ins_ready",  64'(bus.ins_ready),  64'(m_occ < 2));
    check("outs_valid", 64'(bus.outs_valid), 64'(m_occ > 0));
    check("match_cnt",  64'(match_cnt),      64'(sat(m_match, MAX16)));
    check("mis_cnt",    64'(mismatch_cnt),   64'(sat(m_mis, MAX16)));
    check("sticky",     64'(mismatch_sticky), 64'(m_sticky));
    check("first_bad",  64'(first_bad),      64'(m_first));
    check("match_cnt4", 64'(match_cnt4),     64'(sat(m_match, MAX4)));
    check("mis_cnt4",   64'(mismatch_cnt4),  64'(sat(m_mis, MAX4)));
  endtask

  task automatic model_reset();
    m_occ = 0; m_match = 0; m_mis = 0; m_sticky = 1'b0; m_first = '0; last_acc = 1'b0;
  endtask

  // Called at a negedge: apply inputs, advance model over the rising edge, check at next negedge
  task automatic cycle(input bit v, input logic [23:0] d, input bit r);
    bit acc, pop, hit;
    bus.ins        = d;
    bus.ins_valid  = v;
    bus.outs_ready = r;
    acc = v && (m_occ < 2);
    pop = r && (m_occ > 0);
    hit = (d == EXP);
    @(posedge clk);
    if (acc) begin
      if (hit) m_match++;
      else begin
        m_mis++;
        if (!m_sticky) begin m_sticky = 1'b1; m_first = d; end
      end
    end
    if (pop) n_pops++;
    m_occ = m_occ + ((acc && (!DROP || hit)) ? 1 : 0) - (pop ? 1 : 0);
    last_acc = acc;
    @(negedge clk);
    check_all();
  endtask

  task automatic random_phase(input int n, input int ready_pct);
    bit          v;
    logic [23:0] d;
    bit          r;
    v = 1'b0; d = '0;
    for (int i = 0; i < n; i++) begin
      if (!(v && !last_acc)) begin
        v = ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 1) == 0) ? EXP : 24'($urandom);
      end
      r = ($urandom_range(0, 99) < ready_pct);
      cycle(v, d, r);
    end
    cycle(1'b0, 24'h0, 1'b1);
    cycle(1'b0, 24'h0, 1'b1);
  endtask

  initial begin
    int pops_before;
    n_vec = 0; n_err = 0; n_pops = 0;
    model_reset();
    rst = 1'b0;
    bus.ins = '0; bus.ins_valid = 1'b0; bus.outs_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // Stream of matching tokens with downstream always ready
    for (int i = 0; i < 5; i++) cycle(1'b1, EXP, 1'b1);
    cycle(1'b0, 24'h0, 1'b1);
    check("five_pops", 64'(n_pops), 64'd5);

    // Backpressure: exactly two tokens fit
    for (int i = 0; i < 4; i++) cycle(1'b1, EXP, 1'b0);
    check("full_ready", 64'(bus.ins_ready), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b1);

    // Mixed hits and misses; first_bad must hold the first miss
    cycle(1'b1, EXP, 1'b1);
    cycle(1'b1, 24'h000001, 1'b1);
    check("sticky_after_miss", 64'(mismatch_sticky), 64'd1);
    cycle(1'b1, 24'hABCDEF, 1'b1);
    cycle(1'b1, EXP, 1'b1);
    check("first_bad_val", 64'(first_bad), 64'h000001);
    cycle(1'b0, 24'h0, 1'b1);

    // Occupancy held at one with simultaneous accept and pop
    cycle(1'b1, EXP, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, EXP, 1'b1);
    cycle(1'b0, 24'h0, 1'b1);

    // Saturate the narrow counters
    for (int i = 0; i < 20; i++) cycle(1'b1, EXP, 1'b1);
    cycle(1'b0, 24'h0, 1'b1);
    check("sat4", 64'(match_cnt4), 64'hF);

    random_phase(1500, 70);
    random_phase(1000, 25);

    // Asynchronous reset while full with nonzero statistics
    cycle(1'b1, 24'h123456, 1'b0);
    cycle(1'b1, EXP, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    pops_before = n_pops;
    cycle(1'b1, EXP, 1'b1);
    check("post_rst_acc", 64'(last_acc), 64'd1);
    cycle(1'b0, 24'h0, 1'b1);
    check("post_rst_pop", 64'(n_pops - pops_before), 64'd1);

    random_phase(800, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
